addr_state_decoder: RTL and testbench
=====================================

ADDR_STATE_DECODER -- requirements
Module: addr_state_decoder

Interface
REQ-001 Parameter ERR_CNT_W, default 8, width of the saturating error counter.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 addr_in  input  4  address code from the state-to-address encoder.
REQ-005 addr_valid  input  1  addr_in holds a code this cycle.
REQ-006 addr_ready  output  1  decoder accepts addr_in this cycle.
REQ-007 state_out  output  2  decoded state.
REQ-008 state_valid  output  1  state_out/decode_err/seq_err hold a result.
REQ-009 state_ready  input  1  downstream accepts the result this cycle.
REQ-010 decode_err  output  1  current result came from an illegal code.
REQ-011 seq_err  output  1  current result violated the expected code sequence.
REQ-012 err_cnt  output  ERR_CNT_W  count of accepted codes with decode_err or seq_err set.
REQ-013 phase  output  2  sequence FSM state (encoding per REQ-020).

Function
REQ-014 Input handshake: code accepted when addr_valid and addr_ready both 1 on a posedge.
REQ-015 addr_ready = ~state_valid | state_ready (single output register, no skid buffer).
REQ-016 Latency: accepted code appears on state_out/state_valid the next cycle.
REQ-017 Decode: 4'b0000 -> state_out 2'b00; 4'b1111 -> state_out 2'b11 (canonical inverse of all non-zero states); any other code -> state_out 2'b00, decode_err 1.
REQ-018 Output hold: state_valid stays 1 and state_out/decode_err/seq_err stay stable until state_ready is 1; state_valid clears on state_ready without a new accept.
REQ-019 Simultaneous state_ready and accept: new result loaded, state_valid stays 1, no bubble.
REQ-020 FSM phase: IDLE=2'b00, RSTPH=2'b01, RUN=2'b10, FAULT=2'b11; advances only on accepted codes.
REQ-021 IDLE: 0000 -> RSTPH; 1111 -> FAULT with seq_err 1; illegal -> FAULT.
REQ-022 RSTPH: 0000 -> RSTPH; 1111 -> RUN; illegal -> FAULT.
REQ-023 RUN: 1111 -> RUN; 0000 -> RSTPH (encoder re-reset, legal, no error); illegal -> FAULT.
REQ-024 FAULT: 0000 -> RSTPH (recovery, no error); 1111 -> FAULT with seq_err 1; illegal -> FAULT.
REQ-025 seq_err and decode_err are never both 1 for one result; illegal code sets only decode_err.
REQ-026 err_cnt increments by 1 per accepted code yielding an error; saturates at all-ones, never wraps.
REQ-027 No accept while addr_valid is 0; addr_in ignored then.

Reset
REQ-028 rst low asynchronously forces: state_out 2'b00, state_valid 0, decode_err 0, seq_err 0, err_cnt 0, phase IDLE.
REQ-029 Reset mid-transfer discards the held result; no accept occurs in a cycle where rst is low.
REQ-030 First accept possible on the first posedge after rst deasserts.

Structure
REQ-031 Shared package holds: phase enum/constants, ADDR_RST=4'b0000, ADDR_RUN=4'b1111, STATE_RST=2'b00, STATE_RUN=2'b11.
REQ-032 One sub-module, addr_code_decode: combinational addr_in -> {state, illegal}; FSM, output register and counter in the top.

Verification
REQ-033 Reset, then 0000,1111,1111 with state_ready 1 -> state_out 00,11,11; phase RSTPH,RUN,RUN; err_cnt 0.
REQ-034 After reset send 1111 -> seq_err 1, phase FAULT, err_cnt 1; then 0000 -> phase RSTPH, seq_err 0.
REQ-035 Send 0101 in RUN -> state_out 00, decode_err 1, phase FAULT, err_cnt +1.
REQ-036 Hold state_ready 0 two cycles after accept -> addr_ready 0, output stable; raise state_ready with addr_valid 1 -> back-to-back results, no bubble.
REQ-037 ERR_CNT_W=2, send five illegal codes -> err_cnt 1,2,3,3,3.
REQ-038 Assert rst low while state_valid 1 in RUN -> all outputs at REQ-028 values immediately, before next clock edge.

Source files
------------

// File: rtl/addr_state_decoder_pkg.sv
// Shared code, state and phase constants for the address-to-state decoder.
package addr_state_decoder_pkg;

    localparam logic [3:0] ADDR_RST  = 4'b0000;
    localparam logic [3:0] ADDR_RUN  = 4'b1111;
    localparam logic [1:0] STATE_RST = 2'b00;
    localparam logic [1:0] STATE_RUN = 2'b11;

    localparam logic [1:0] PH_IDLE  = 2'b00;
    localparam logic [1:0] PH_RSTPH = 2'b01;
    localparam logic [1:0] PH_RUN   = 2'b10;
    localparam logic [1:0] PH_FAULT = 2'b11;

    typedef struct packed {
        logic [1:0] state;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/addr_code_decode.sv
// Combinational map of a 4-bit address code to a 2-bit state plus an illegal flag.
module addr_code_decode
    import addr_state_decoder_pkg::*;
(
    input  logic [3:0] i_addr,
    output dec_t       o_dec
);

    always_comb begin
        o_dec = '{state: STATE_RST, illegal: 1'b0};
        if (i_addr == ADDR_RUN)
            o_dec.state = STATE_RUN;
        else if (i_addr != ADDR_RST)
            o_dec.illegal = 1'b1;
    end

endmodule

// File: rtl/addr_state_decoder.sv
// Decodes encoder address codes into states, tracks the expected code sequence
// and counts errors; one registered result slot with valid/ready on both sides.
module addr_state_decoder
    import addr_state_decoder_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           addr_in,
    input  logic                 addr_valid,
    output logic                 addr_ready,
    output logic [1:0]           state_out,
    output logic                 state_valid,
    input  logic                 state_ready,
    output logic                 decode_err,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [1:0]           phase
);

    dec_t                 w_dec;
    logic                 w_accept;
    logic [1:0]           w_nxt_phase;
    logic                 w_seq_err;
    logic [1:0]           r_phase;
    logic [1:0]           r_state;
    logic                 r_valid;
    logic                 r_derr;
    logic                 r_serr;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    addr_code_decode u_dec (
        .i_addr (addr_in),
        .o_dec  (w_dec)
    );

    assign addr_ready = ~r_valid | state_ready;
    assign w_accept   = addr_valid & addr_ready;

    // 0000 always (re)enters RSTPH; 1111 is only expected once RSTPH has been seen.
    always_comb begin
        w_nxt_phase = r_phase;
        w_seq_err   = 1'b0;
        if (w_dec.illegal) begin
            w_nxt_phase = PH_FAULT;
        end else if (addr_in == ADDR_RST) begin
            w_nxt_phase = PH_RSTPH;
        end else begin
            case (r_phase)
                PH_RSTPH, PH_RUN: w_nxt_phase = PH_RUN;
                default: begin
                    w_nxt_phase = PH_FAULT;
                    w_seq_err   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase   <= PH_IDLE;
            r_state   <= STATE_RST;
            r_valid   <= 1'b0;
            r_derr    <= 1'b0;
            r_serr    <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_accept) begin
            r_phase <= w_nxt_phase;
            r_state <= w_dec.state;
            r_valid <= 1'b1;
            r_derr  <= w_dec.illegal;
            r_serr  <= w_seq_err;
            if ((w_dec.illegal | w_seq_err) && (r_err_cnt != {ERR_CNT_W{1'b1}}))
                r_err_cnt <= r_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else if (state_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign state_out   = r_state;
    assign state_valid = r_valid;
    assign decode_err  = r_derr;
    assign seq_err     = r_serr;
    assign err_cnt     = r_err_cnt;
    assign phase       = r_phase;

endmodule

// File: tb/tb_addr_state_decoder.sv
// Directed bench for addr_state_decoder: vector table plus handshake/reset corners.
module tb_addr_state_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] addr_in;
    logic       addr_valid;
    logic       state_ready;
    logic       addr_ready,  addr_ready2;
    logic [1:0] state_out,   state_out2;
    logic       state_valid, state_valid2;
    logic       decode_err,  decode_err2;
    logic       seq_err,     seq_err2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;
    logic [1:0] phase,       phase2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addr_state_decoder #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .state_out(state_out), .state_valid(state_valid),
        .state_ready(state_ready), .decode_err(decode_err), .seq_err(seq_err),
        .err_cnt(err_cnt), .phase(phase)
    );

    addr_state_decoder #(.ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .addr_in(addr_in), .addr_valid(addr_valid),
        .addr_ready(addr_ready2), .state_out(state_out2), .state_valid(state_valid2),
        .state_ready(state_ready), .decode_err(decode_err2), .seq_err(seq_err2),
        .err_cnt(err_cnt2), .phase(phase2)
    );

    typedef struct {
        logic       vld;
        logic [3:0] addr;
        logic [1:0] st;
        logic       sv;
        logic       derr;
        logic       serr;
        logic [1:0] ph;
        int         cnt;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic sv,
                           input logic de, input logic se, input logic [1:0] ph, input int cnt);
        chk({tag, " state_out"},   int'(state_out),   int'(st));
        chk({tag, " state_valid"}, int'(state_valid), int'(sv));
        chk({tag, " decode_err"},  int'(decode_err),  int'(de));
        chk({tag, " seq_err"},     int'(seq_err),     int'(se));
        chk({tag, " phase"},       int'(phase),       int'(ph));
        chk({tag, " err_cnt"},     int'(err_cnt),     cnt);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; addr_valid = 1'b0; addr_in = 4'b0000; state_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b1;
    endtask

    vec_t vt[12];

    initial begin
        rst = 1'b0; addr_valid = 1'b0; addr_in = 4'b0000; state_ready = 1'b1;
        vt[0]  = '{1'b1, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 0};
        vt[1]  = '{1'b1, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 0};
        vt[2]  = '{1'b1, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 0};
        vt[3]  = '{1'b1, 4'b0101, 2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 1};
        vt[4]  = '{1'b1, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b1, 2'b11, 2};
        vt[5]  = '{1'b1, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 2};
        vt[6]  = '{1'b0, 4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2};
        vt[7]  = '{1'b1, 4'b0011, 2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 3};
        vt[8]  = '{1'b1, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 3};
        vt[9]  = '{1'b1, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 3};
        vt[10] = '{1'b1, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 3};
        vt[11] = '{1'b1, 4'b1000, 2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 4};

        // reset state
        #2;
        chk_all("reset", 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 0);
        cyc();
        rst = 1'b1;

        // table: first accept on first edge after reset release
        for (int i = 0; i < 12; i++) begin
            addr_valid = vt[i].vld; addr_in = vt[i].addr; state_ready = 1'b1;
            cyc();
            chk_all($sformatf("vec%0d", i), vt[i].st, vt[i].sv, vt[i].derr,
                    vt[i].serr, vt[i].ph, vt[i].cnt);
        end

        // 1111 straight out of IDLE is a sequence error, 0000 recovers
        do_reset();
        addr_valid = 1'b1; addr_in = 4'b1111;
        cyc();
        chk_all("idle_run", 2'b11, 1'b1, 1'b0, 1'b1, 2'b11, 1);
        addr_in = 4'b0000;
        cyc();
        chk_all("recover", 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1);

        // backpressure: result held, no accept, then back-to-back
        addr_valid = 1'b0;
        cyc();
        chk("drain state_valid", int'(state_valid), 0);
        addr_valid = 1'b1; addr_in = 4'b1111;
        cyc();
        chk_all("bp_load", 2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 1);
        state_ready = 1'b0; addr_in = 4'b0101;
        #1;
        chk("bp addr_ready", int'(addr_ready), 0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk_all($sformatf("bp_hold%0d", k), 2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 1);
            chk($sformatf("bp_hold%0d addr_ready", k), int'(addr_ready), 0);
        end
        state_ready = 1'b1; addr_in = 4'b0000;
        #1;
        chk("bp release addr_ready", int'(addr_ready), 1);
        cyc();
        chk_all("b2b0", 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1);
        addr_in = 4'b1111;
        cyc();
        chk_all("b2b1", 2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 1);

        // async reset while a RUN result is held
        state_ready = 1'b0;
        cyc();
        chk("pre-rst state_valid", int'(state_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 0);
        state_ready = 1'b1; addr_valid = 1'b1; addr_in = 4'b0000;
        cyc();
        chk("no accept in reset", int'(state_valid), 0);
        rst = 1'b1;
        cyc();
        chk_all("post_rst_accept", 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 0);

        // saturation of the 2-bit counter on five illegal codes
        do_reset();
        for (int k = 0; k < 5; k++) begin
            addr_valid = 1'b1; addr_in = 4'(k + 1);
            cyc();
            chk($sformatf("sat%0d err_cnt2", k), int'(err_cnt2), (k < 3) ? k + 1 : 3);
            chk($sformatf("sat%0d err_cnt", k), int'(err_cnt), k + 1);
            chk($sformatf("sat%0d decode_err2", k), int'(decode_err2), 1);
        end

        addr_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
